// File: rtl/dmem_arbiter.sv
// dmem_arbiter: 8-word data memory shared by the CPU MEM stage (port C) and
// the host/debug loader (port D). Single-cycle accesses, round-robin on
// contested cycles, and a bounded debug lock that gives port D exclusive
// ownership.
//
// Ports
//   CLK, RST                         clock, asynchronous active-high reset
//   c_req_i/c_we_i/c_addr_i/c_wdata_i  CPU request fields
//   c_gnt_o, c_stall_o               CPU grant / stall (combinational)
//   c_rvalid_o, c_rdata_o            CPU load data, one cycle after grant
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  debug request fields
//   d_lock_i                         debug asks for exclusive ownership
//   d_gnt_o                          debug grant (combinational)
//   d_rvalid_o, d_rdata_o            debug load data, one cycle after grant
//   addr_err_o                       one-cycle pulse: granted access out of range
//   stall_cnt_o                      saturating count of CPU stall cycles
module dmem_arbiter #(
    parameter int DW       = 32,
    parameter int AW       = 3,
    parameter int DEPTH    = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdata_i,
    output logic          c_gnt_o,
    output logic          c_stall_o,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    input  logic          d_lock_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,
    output logic          addr_err_o,
    output logic [15:0]   stall_cnt_o
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    // One extra bit so DEPTH == 2^AW is representable.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic {ARB, LOCK} state_e;

    state_e          state_q;
    logic            last_q;      // 1: D won the last contest, 0: C did
    logic [CW-1:0]   lock_cnt_q;

    logic [DW-1:0]   mem_q [DEPTH];
    logic            c_rvalid_q, d_rvalid_q, addr_err_q;
    logic [DW-1:0]   c_rdata_q, d_rdata_q;
    logic [15:0]     stall_cnt_q;

    logic            c_gnt, d_gnt, c_fire, d_fire, c_oob, d_oob;
    logic [DW-1:0]   c_rd_word, d_rd_word;
    logic [CW-1:0]   lock_cnt_inc;

    // Zero-latency grant decision.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        case (state_q)
            ARB: begin
                if (c_req_i && d_req_i) begin
                    c_gnt = last_q;
                    d_gnt = ~last_q;
                end else begin
                    c_gnt = c_req_i;
                    d_gnt = d_req_i;
                end
            end
            LOCK: d_gnt = d_req_i;
            default: ;
        endcase
    end

    assign c_fire = c_req_i & c_gnt;
    assign d_fire = d_req_i & d_gnt;
    assign c_oob  = {1'b0, c_addr_i} >= DEPTH_W;
    assign d_oob  = {1'b0, d_addr_i} >= DEPTH_W;

    // Read muxes: an out-of-range address matches no word and yields 0.
    always_comb begin
        c_rd_word = '0;
        d_rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_addr_i == AW'(i)) c_rd_word = mem_q[i];
            if (d_addr_i == AW'(i)) d_rd_word = mem_q[i];
        end
    end

    assign lock_cnt_inc = lock_cnt_q + CW'(1);

    // Arbitration / lock state machine.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ARB;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (c_req_i && d_req_i) last_q <= d_gnt;
                    if (d_fire && d_lock_i) begin
                        state_q    <= LOCK;
                        lock_cnt_q <= '0;
                    end
                end
                LOCK: begin
                    lock_cnt_q <= lock_cnt_inc;
                    if (!d_lock_i) begin
                        state_q <= ARB;
                    end else if (lock_cnt_inc == CW'(LOCK_MAX)) begin
                        // Forced release: hand the next contest to the CPU.
                        state_q <= ARB;
                        last_q  <= 1'b1;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // Memory and registered responses. Only one port fires per cycle, so
    // the two write enables never collide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DW'(i - 3);
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
            addr_err_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (c_fire && c_we_i && c_addr_i == AW'(i)) mem_q[i] <= c_wdata_i;
                if (d_fire && d_we_i && d_addr_i == AW'(i)) mem_q[i] <= d_wdata_i;
            end
            c_rvalid_q <= c_fire & ~c_we_i;
            d_rvalid_q <= d_fire & ~d_we_i;
            if (c_fire && !c_we_i) c_rdata_q <= c_rd_word;
            if (d_fire && !d_we_i) d_rdata_q <= d_rd_word;
            addr_err_q <= (c_fire & c_oob) | (d_fire & d_oob);
            if (c_stall_o && stall_cnt_q != 16'hFFFF)
                stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign c_gnt_o     = c_gnt;
    assign d_gnt_o     = d_gnt;
    assign c_stall_o   = c_req_i & ~c_gnt;
    assign c_rvalid_o  = c_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign c_rdata_o   = c_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign addr_err_o  = addr_err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by a constrained
// random phase, all checked against a cycle-level reference model.
module tb_dmem_arbiter;
    localparam int DW = 32, AW = 4, DEPTH = 8, LOCK_MAX = 16;

    logic          CLK = 1'b0, RST;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, addr_err;
    logic [DW-1:0] c_rdata, d_rdata;
    logic [15:0]   stall_cnt;

    dmem_arbiter #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
        .c_gnt_o(c_gnt), .c_stall_o(c_stall), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_lock_i(d_lock), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .addr_err_o(addr_err), .stall_cnt_o(stall_cnt)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errs = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_lock, m_last_d;
    int            m_lock_cycles, m_stall;
    bit            m_crv, m_drv, m_err, eg_c, eg_d;
    logic [DW-1:0] m_crd, m_drd;

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = DW'(i - 3);
        m_lock = 0; m_last_d = 1; m_lock_cycles = 0; m_stall = 0;
        m_crv = 0; m_drv = 0; m_err = 0; m_crd = '0; m_drd = '0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_regs(input string pfx);
        chk({pfx, ".c_rvalid"}, DW'(c_rvalid), DW'(m_crv));
        chk({pfx, ".d_rvalid"}, DW'(d_rvalid), DW'(m_drv));
        chk({pfx, ".c_rdata"}, c_rdata, m_crd);
        chk({pfx, ".d_rdata"}, d_rdata, m_drd);
        chk({pfx, ".addr_err"}, DW'(addr_err), DW'(m_err));
        chk({pfx, ".stall_cnt"}, DW'(stall_cnt), DW'(m_stall));
    endtask

    // One clock cycle: drive, check grants, predict the edge, check results.
    task automatic step(input string tag,
                        input bit cr, input bit cw, input int ca, input logic [DW-1:0] cd,
                        input bit dr, input bit dw, input int da, input logic [DW-1:0] dd,
                        input bit dl);
        c_req = cr; c_we = cw; c_addr = AW'(ca); c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = AW'(da); d_wdata = dd; d_lock = dl;
        #1;
        if (m_lock)        begin eg_c = 0;        eg_d = dr;        end
        else if (cr && dr) begin eg_c = m_last_d; eg_d = !m_last_d; end
        else               begin eg_c = cr;       eg_d = dr;        end
        chk({tag, ".c_gnt"}, DW'(c_gnt), DW'(eg_c));
        chk({tag, ".d_gnt"}, DW'(d_gnt), DW'(eg_d));
        chk({tag, ".c_stall"}, DW'(c_stall), DW'(cr && !eg_c));

        if (cr && !eg_c && m_stall < 65535) m_stall++;
        m_err = (eg_c && ca >= DEPTH) || (eg_d && da >= DEPTH);
        m_crv = eg_c && !cw;
        m_drv = eg_d && !dw;
        if (m_crv) m_crd = (ca < DEPTH) ? m_mem[ca] : '0;
        if (m_drv) m_drd = (da < DEPTH) ? m_mem[da] : '0;
        if (eg_c && cw && ca < DEPTH) m_mem[ca] = cd;
        if (eg_d && dw && da < DEPTH) m_mem[da] = dd;
        if (m_lock) begin
            m_lock_cycles++;
            if (!dl) m_lock = 0;
            else if (m_lock_cycles == LOCK_MAX) begin m_lock = 0; m_last_d = 1; end
        end else begin
            if (cr && dr) m_last_d = eg_d;
            if (eg_d && dl) begin m_lock = 1; m_lock_cycles = 0; end
        end

        @(posedge CLK); #1;
        chk_regs(tag);
    endtask

    bit            pc, pd, cr, cw, dr, dw, dl;
    int            ca, da;
    logic [DW-1:0] cd, dd;

    initial begin
        RST = 1'b1;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
        m_reset();
        #3;
        chk_regs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;

        // CPU reads every word back to back.
        for (int a = 0; a < 8; a++) step("seqrd", 1, 0, a, '0, 0, 0, 0, '0, 0);
        chk("seqrd.last", c_rdata, 32'd4);

        // Both ports contend for address 5.
        for (int k = 0; k < 4; k++) step("contend", 1, 0, 5, '0, 1, 0, 5, '0, 0);
        chk("contend.stall_cnt", DW'(stall_cnt), 32'd2);

        // Write then read-back on consecutive cycles.
        step("wr3", 1, 1, 3, 32'hDEADBEEF, 0, 0, 0, '0, 0);
        step("rd3", 1, 0, 3, '0, 0, 0, 0, '0, 0);
        chk("rd3.data", c_rdata, 32'hDEADBEEF);

        // Debug lock held while the CPU keeps requesting.
        for (int k = 0; k < 20; k++)
            step("lock", 1, 0, 1, '0, 1, 0, k % 8, '0, 1);

        // Out-of-range debug write then read.
        step("oobwr", 0, 0, 0, '0, 1, 1, 9, 32'd7, 0);
        chk("oobwr.addr_err", DW'(addr_err), 32'd1);
        step("oobrd", 0, 0, 0, '0, 1, 0, 9, '0, 0);
        chk("oobrd.d_rdata", d_rdata, 32'd0);
        chk("oobrd.d_rvalid", DW'(d_rvalid), 32'd1);
        step("oobidle", 0, 0, 0, '0, 0, 0, 0, '0, 0);

        // Random traffic; ungranted requests mostly hold, sometimes drop.
        pc = 0; pd = 0;
        cr = 0; cw = 0; ca = 0; cd = '0; dr = 0; dw = 0; da = 0; dd = '0; dl = 0;
        for (int k = 0; k < 400; k++) begin
            if (!(pc && $urandom_range(0, 3) != 0)) begin
                cr = $urandom_range(0, 2) != 0; cw = $urandom_range(0, 1) == 1;
                ca = $urandom_range(0, 9);      cd = $urandom;
            end
            if (!(pd && $urandom_range(0, 3) != 0)) begin
                dr = $urandom_range(0, 2) != 0; dw = $urandom_range(0, 1) == 1;
                da = $urandom_range(0, 9);      dd = $urandom;
            end
            dl = $urandom_range(0, 7) == 0 || (m_lock && $urandom_range(0, 7) != 0);
            step("rand", cr, cw, ca, cd, dr, dw, da, dd, dl);
            pc = cr && !eg_c;
            pd = dr && !eg_d;
        end

        // Reset during LOCK with a debug read in flight.
        step("lkent", 0, 0, 0, '0, 1, 0, 2, '0, 1);
        step("lkrd", 1, 0, 0, '0, 1, 0, 6, '0, 1);
        RST = 1'b1;
        #1;
        m_reset();
        chk_regs("midrst");
        c_req = 0; d_req = 0; d_lock = 0;
        @(posedge CLK); #1;
        RST = 1'b0;
        step("postrst", 1, 0, 0, '0, 0, 0, 0, '0, 0);
        chk("postrst.mem0", c_rdata, 32'hFFFFFFFD);
        step("postrst2", 1, 0, 4, '0, 1, 0, 7, '0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shared data-memory block for the 4-register pipelined CPU. It owns the 8-word × 32-bit data memory and arbitrates single-cycle accesses between the CPU MEM stage (port C) and the host/debug loader (port D). Contested cycles are resolved round-robin. Port D can lock the memory for bounded bursts. The block drives a stall to the pipeline whenever a CPU request is not granted.

## Interface
- DW, 32, data width
- AW, 3, address width
- DEPTH, 8, implemented words; must satisfy DEPTH ≤ 2^AW
- LOCK_MAX, 16, maximum consecutive cycles in the debug-lock state
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- c_req / c_we  in  1 / 1  CPU request / write-enable (1 = store, 0 = load)
- c_addr  in  AW  CPU word address
- c_wdata  in  DW  CPU store data
- c_gnt  out  1  CPU granted this cycle (combinational)
- c_stall  out  1  c_req & ~c_gnt (combinational)
- c_rvalid / c_rdata  out  1 / DW  CPU load data, registered
- d_req / d_we / d_addr / d_wdata  in  1/1/AW/DW  debug request fields, same meaning as the CPU port
- d_lock  in  1  debug requests exclusive ownership
- d_gnt  out  1  debug granted this cycle (combinational)
- d_rvalid / d_rdata  out  1 / DW  debug load data, registered
- addr_err  out  1  registered one-cycle pulse: a granted access used addr ≥ DEPTH
- stall_cnt  out  16  saturating count of cycles with c_stall = 1

## Operation
- State machine: ARB (normal arbitration) and LOCK (debug owns the memory). Register `last` holds the port of the most recent contested grant (C or D).
- ARB grants:
  - Only one request active: that port is granted.
  - Both active: the port that is not `last` is granted, then `last` is updated.
  - Uncontested grants do not change `last`.
- LOCK grants: d_gnt = d_req and c_gnt = 0, unconditionally.
- ARB → LOCK: at an edge where d_req & d_gnt & d_lock.
- LOCK → ARB:
  - At the first edge where d_lock = 0.
  - Or forced at the edge where the lock counter reaches LOCK_MAX. A forced exit sets last = D, so the CPU wins the next contest.
- Lock counter: cleared on entry, increments each cycle in LOCK.
- Access commits at the edge where req & gnt:
  - Write: mem[addr] ← wdata.
  - Read: rdata ← mem[addr], and rvalid = 1 for the next cycle only.
  - rdata holds its value when rvalid = 0.
- Out-of-range address (addr ≥ DEPTH): write dropped, read returns 0 with rvalid = 1, addr_err pulses.
- At most one port is granted per cycle, so there are no same-cycle read/write collisions.
- stall_cnt increments on each edge where c_stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate):
  - State ARB, last = D, lock counter 0.
  - c_rvalid = d_rvalid = 0, c_rdata = d_rdata = 0, addr_err = 0, stall_cnt = 0.
  - mem[i] = i − 3 in two's complement, i.e. −3, −2, −1, 0, 1, 2, 3, 4.
- Grant: same cycle as the request, zero latency.
- Read latency: 1. Data is valid in the cycle after the granted request.
- Handshake:
  - An ungranted requester holds req, we, addr and wdata stable until granted.
  - Dropping req before grant cancels the request with no side effect.
- Read-after-write to the same address on consecutive granted cycles returns the new data.
- Reset mid-LOCK or mid-read:
  - Returns to ARB immediately.
  - Any pending rvalid is suppressed.
  - Memory is re-initialised to the reset values.
- When no requests are active: no grants, no state change, and the LOCK counter still advances while in LOCK.

## Test plan
- Reset, then a CPU read of each address 0–7 back-to-back → c_gnt = 1 every cycle; c_rdata = −3…4 in the following cycles; d_rvalid = 0 throughout.
- Both ports read address 5 for 4 cycles → grants C, D, C, D; the granted port gets rvalid with value 2 one cycle later; stall_cnt = 2.
- CPU writes 0xDEADBEEF to address 3, then reads address 3 on the next cycle → c_rdata = 0xDEADBEEF with c_rvalid = 1; mem[3] = 0xDEADBEEF.
- Debug asserts d_lock with d_req for 20 cycles while c_req = 1 → c_gnt = 0 and c_stall = 1 for 16 lock cycles plus the entry cycle; forced exit after LOCK_MAX; c_gnt = 1 on the next contested cycle.
- Debug writes 7 to address 9 with DEPTH = 8 → no memory change; addr_err = 1 for one cycle; a subsequent read of address 9 returns 0 with d_rvalid = 1.
- RST pulsed during LOCK with a read in flight → no rvalid after reset; state ARB; mem[0] reads −3; stall_cnt = 0.
